// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling UART receiver; deserialises start/data/stop frames,
// rejects false starts and flags framing errors with a one-cycle done strobe.
module uart_rx_fsm #(
    parameter int D_BIT   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             s_tick,
    output logic             rx_done_tick,
    output logic [D_BIT-1:0] dout,
    output logic             frame_err,
    output logic             busy
);
    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (D_BIT > 1) ? $clog2(D_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [S_W-1:0]   s, s_n;
    logic [N_W-1:0]   n, n_n;
    logic [D_BIT-1:0] shreg, shreg_n, dout_n;
    logic             rx_m, rx_s, done_n, ferr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_m         <= rx;
            rx_s         <= rx_m;
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            shreg        <= shreg_n;
            dout         <= dout_n;
            rx_done_tick <= done_n;
            frame_err    <= ferr_n;
            busy         <= (state_n != IDLE);
        end
    end

    // tick counter s times the half-bit to mid-start, then full bits to each centre
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_W'(7)) begin
                        state_n = rx_s ? IDLE : DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_W'(15)) begin
                        s_n     = '0;
                        shreg_n = {rx_s, shreg[D_BIT-1:1]};
                        if (n == N_W'(D_BIT-1)) state_n = STOP;
                        else n_n = n + N_W'(1);
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_W'(SB_TICK-1)) state_n = IDLE;
                    else s_n = s + S_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        done_n = (state == STOP) && s_tick && (s == S_W'(SB_TICK-1));
        dout_n = done_n ? shreg : dout;
        ferr_n = done_n ? ~rx_s : frame_err;
    end
endmodule
